// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared types, constants and error decode for dmem_wait_responder
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int DMEM_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Error causes are one-hot so several can be reported together.
  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_MISALIGN = 3'b001;
  localparam logic [2:0] ERR_RANGE    = 3'b010;
  localparam logic [2:0] ERR_BOTH     = 3'b100;

  function automatic logic [2:0] dmem_err_cause(
    input logic [31:0] adr,
    input logic        rd,
    input logic        wr,
    input int unsigned depth
  );
    logic [2:0] cause;
    cause = ERR_NONE;
    if (adr[1:0] != 2'b00)
      cause = cause | ERR_MISALIGN;
    if ({2'b00, adr[31:2]} >= depth)
      cause = cause | ERR_RANGE;
    if (rd && wr)
      cause = cause | ERR_BOTH;
    return cause;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_wait_responder_if.sv
// ============================================================================
// dmem_wait_responder_if : core data-memory port (core = master, memory = slave)
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_wait_responder_if;

  logic [31:0] adr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        ready;
  logic        error;

  modport master (
    output adr, wdata, mem_read, mem_write,
    input  rdata, ready, error
  );

  modport slave (
    input  adr, wdata, mem_read, mem_write,
    output rdata, ready, error
  );

endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// dmem_array : DEPTH_WORDS x 32 storage, synchronous write, combinational read
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_idx,
  input  wire logic [31:0]   i_wdata,
  output logic      [31:0]   o_rdata
);

  // Contents are deliberately left unreset so they survive a core reset.
  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/dmem_wait_responder.sv
// ============================================================================
// dmem_wait_responder : data-memory slave with programmable wait states
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  dmem_wait_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_CNT_W-1:0] c_WAIT_CNT = DMEM_CNT_W'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_wait_responder: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH_WORDS < 4 || DEPTH_WORDS > 65536 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_wait_responder: DEPTH_WORDS must be a power of 2 in 4..65536");
  end

  dmem_state_t           r_state;
  dmem_state_t           w_next;
  logic [DMEM_CNT_W-1:0] r_cnt;
  logic [31:0]           r_adr;
  logic [31:0]           r_wdata;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_ready;
  logic                  r_error;
  logic [31:0]           r_rdata;

  logic                  w_req;
  logic                  w_sample;
  logic [31:0]           w_op_adr;
  logic [31:0]           w_op_wdata;
  logic                  w_op_rd;
  logic                  w_op_wr;
  logic                  w_err;
  logic                  w_enter;
  logic                  w_we;
  logic [31:0]           w_mem_rdata;

  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_sample = (r_state == IDLE) && w_req;

  // With zero wait states the access happens on the sampling edge itself,
  // so the live request is used there; otherwise the latched copy.
  assign w_op_adr   = (r_state == IDLE) ? bus.adr       : r_adr;
  assign w_op_wdata = (r_state == IDLE) ? bus.wdata     : r_wdata;
  assign w_op_rd    = (r_state == IDLE) ? bus.mem_read  : r_rd;
  assign w_op_wr    = (r_state == IDLE) ? bus.mem_write : r_wr;
  assign w_err      = |dmem_err_cause(w_op_adr, w_op_rd, w_op_wr, DEPTH_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (r_cnt == DMEM_CNT_W'(1)) w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_enter = (w_next == RESP);
    w_we    = w_enter && w_op_wr && !w_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_enter;
      r_error <= w_enter && w_err;
      if (w_sample) begin
        r_adr   <= bus.adr;
        r_wdata <= bus.wdata;
        r_rd    <= bus.mem_read;
        r_wr    <= bus.mem_write;
        r_cnt   <= c_WAIT_CNT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - DMEM_CNT_W'(1);
      end else if (r_state == RESP) begin
        r_cnt <= '0;
      end
      // Any rejected access clears rdata; successful writes leave it alone.
      if (w_enter && (w_op_rd || w_err))
        r_rdata <= w_err ? 32'h0 : w_mem_rdata;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_op_adr[AW+1:2]),
    .i_wdata (w_op_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign bus.ready = r_ready;
  assign bus.error = r_error;
  assign bus.rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
// ============================================================================
// tb_dmem_wait_responder : two instances (0 and 2 wait states) vs. a word-array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_wait_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_wait_responder_if bus0 ();
  dmem_wait_responder_if bus2 ();

  dmem_wait_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  dmem_wait_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mem_m  [2][DEPTH];
  logic [31:0] exp_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wc(input int s);
    return (s == 0) ? 0 : 2;
  endfunction
  function automatic logic rdy(input int s);
    return (s == 0) ? bus0.ready : bus2.ready;
  endfunction
  function automatic logic errf(input int s);
    return (s == 0) ? bus0.error : bus2.error;
  endfunction
  function automatic logic [31:0] rdat(input int s);
    return (s == 0) ? bus0.rdata : bus2.rdata;
  endfunction

  task automatic drive(input int s, input logic [31:0] a, input logic [31:0] w,
                       input logic rd, input logic wr);
    if (s == 0) begin
      bus0.adr = a; bus0.wdata = w; bus0.mem_read = rd; bus0.mem_write = wr;
    end else begin
      bus2.adr = a; bus2.wdata = w; bus2.mem_read = rd; bus2.mem_write = wr;
    end
  endtask

  // One core access, called at a negedge. chained: issued while the previous
  // pulse is visible; hold: leave the request up for a following chained one.
  task automatic access(input int s, input logic [31:0] a, input logic [31:0] w,
                        input logic rd, input logic wr, input bit chained, input bit hold);
    int         n;
    int         idx;
    logic [2:0] cause;
    logic       err;
    drive(s, a, w, rd, wr);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(s) && n < 40);
    check("latency", n, wc(s) + (chained ? 2 : 1));

    cause = ERR_NONE;
    if (a % 4 != 0)        cause = cause | ERR_MISALIGN;
    if (a / 4 >= DEPTH)    cause = cause | ERR_RANGE;
    if (rd && wr)          cause = cause | ERR_BOTH;
    err = (cause != ERR_NONE);
    if (err) begin
      exp_rd[s] = 32'h0;
    end else begin
      idx = int'(a / 4);
      if (wr) mem_m[s][idx] = w;
      if (rd) exp_rd[s] = mem_m[s][idx];
    end
    check("error", errf(s), err);
    check("rdata", rdat(s), exp_rd[s]);

    if (!hold) begin
      drive(s, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      check("ready_pulse_once", rdy(s), 1'b0);
      check("error_low", errf(s), 1'b0);
      check("rdata_held", rdat(s), exp_rd[s]);
    end
  endtask

  initial begin
    int s, len, k;
    logic [31:0] a, w;
    logic rd, wr;

    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    exp_rd[0] = 0;
    exp_rd[1] = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", rdy(i), 1'b0);
      check("reset_error", errf(i), 1'b0);
      check("reset_rdata", rdat(i), 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Give every word a known value so any later read has a defined result.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++)
        access(i, 32'(j * 4), $urandom, 1'b0, 1'b1, 1'b0, 1'b0);

    // Directed scenarios
    access(1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    access(1, 32'h10, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
    access(0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1);
    access(0, 32'h4,  32'h0,        1'b1, 1'b0, 1'b1, 1'b0);
    access(1, 32'h13, 32'h1,        1'b0, 1'b1, 1'b0, 1'b0);
    access(1, 32'h10, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
    access(1, 32'(DEPTH * 4), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    access(1, 32'h10, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0);
    access(1, 32'h10, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
    check("directed_readback", rdat(1), 32'hDEADBEEF);

    // Reset in the middle of a write's wait states
    access(1, 32'h20, 32'h5, 1'b0, 1'b1, 1'b0, 1'b0);
    access(1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1, 32'h20, 32'hAAAA5555, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ready", rdy(1), 1'b0);
    check("async_rst_error", errf(1), 1'b0);
    check("async_rst_rdata", rdat(1), 32'h0);
    check("async_rst_rdata0", rdat(0), 32'h0);
    exp_rd[0] = 0;
    exp_rd[1] = 0;
    drive(1, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_ready", rdy(1), 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    access(1, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("aborted_write", rdat(1), 32'h5);

    // Random bursts of back-to-back accesses
    for (int b = 0; b < 60; b++) begin
      s   = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        k = int'($urandom_range(0, 9));
        a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        if (k == 7) a = a | 32'($urandom_range(1, 3));
        if (k >= 8) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 4;
        k  = int'($urandom_range(0, 9));
        rd = (k < 5) || (k == 9);
        wr = (k >= 5);
        w  = $urandom;
        access(s, a, w, rd, wr, i > 0, i < len - 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_wait_responder.md
# dmem_wait_responder

Data-memory responder for the pipelined MIPS core: the slave end of the core's data-memory port (address, write data, read/write strobes in; read data out). Each access takes a programmable number of wait states, and the block signals completion with a one-cycle `ready` pulse. The hazard unit stalls the core with `stall = (mem_read | mem_write) & ~ready`. The core holds the request stable until `ready`.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of 2, range 4..65536.
- `WAIT_CYCLES`, default 2: wait states per access, range 0..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `adr` in 32: byte address, from the EX/MEM ALU result.
- `wdata` in 32: write data, from the EX/MEM forwarded rt value.
- `mem_read` in 1: read request.
- `mem_write` in 1: write request.
- `rdata` out 32: read data; valid while `ready` is high, then held.
- `ready` out 1: one-cycle completion pulse.
- `error` out 1: qualifies `ready`; the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `mem_read | mem_write` at an edge: latch `adr`, `wdata` and the operation, load `cnt = WAIT_CYCLES`.
  - Go to RESP if `WAIT_CYCLES == 0`, otherwise go to WAIT.
- WAIT:
  - `cnt` decrements each edge.
  - On the edge where `cnt == 1`, go to RESP.
  - Request inputs are ignored; only the latched copy is used.
- RESP:
  - `ready = 1` for exactly one cycle, then return to IDLE.
  - Requests present during RESP are not sampled. The core advances on the edge that ends RESP, so the same request is never served twice.
- Access is performed on the edge that enters RESP:
  - Write: `mem[adr[n+1:2]] <= wdata`, where `n = log2(DEPTH_WORDS)`.
  - Read: `rdata <= mem[adr[n+1:2]]`.
- Error conditions, checked on the latched request. Any one of them means no memory update, `rdata <= 0`, and `error = 1` during RESP:
  - `adr[1:0] != 0` (misaligned);
  - `adr[31:2] >= DEPTH_WORDS` (out of range);
  - `mem_read & mem_write` both set.
- Outputs:
  - `error` is 0 outside RESP.
  - `rdata` holds its value from the last read response (successful or error) until the next read response; writes do not change it.
- Memory contents are not initialised by reset and are retained across reset.

## Timing
- Reset values (asynchronous, while `rst == 0`): state IDLE, `cnt = 0`, `ready = 0`, `error = 0`, `rdata = 0`.
- Latency: request sampled at edge E gives `ready` high in the cycle after edge `E + WAIT_CYCLES`.
  - `WAIT_CYCLES = 0`: `ready` is high the cycle after sampling (1-cycle stall).
- Throughput: one access per `WAIT_CYCLES + 2` cycles when requests are back-to-back.
- Outputs: `ready`, `error` and `rdata` are registered; there is no combinational path from the inputs.
- A request deasserted during WAIT is still completed (pulse issued); the core must not do this.
- Reset during WAIT or RESP:
  - The access is aborted; a pending write is not performed.
  - `ready` drops immediately.
  - After `rst` rises, the FSM samples fresh from IDLE.
- Counter width is 4 bits, with no wrap. A `WAIT_CYCLES` value above 15 is a parameter error and must be caught by an elaboration-time assertion.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - `DMEM_CNT_W = 4`;
  - the error-cause localparams used by the bench.
- One sub-module `dmem_array`:
  - a `DEPTH_WORDS` x 32 storage array;
  - synchronous write with enable, combinational read by word index.
- Top level: FSM, counter, request latch, error decode, output registers.

## Test plan
- Reset: drive `rst = 0` mid-cycle -> `ready = 0`, `error = 0`, `rdata = 0` immediately, with no clock edge needed.
- Write then read, `WAIT_CYCLES = 2`:
  - Write `adr = 0x10`, `wdata = 0xDEADBEEF` -> `ready` pulses 3 cycles after sampling, with `error = 0`.
  - Then read `0x10` -> `rdata = 0xDEADBEEF` with its `ready` pulse; `rdata` is held afterwards.
- `WAIT_CYCLES = 0`, back-to-back reads of `0x0` and `0x4` held by a model of the stalling core -> the pulses are 2 cycles apart, and each access is served once.
- Misaligned write `adr = 0x13`, `wdata = 0x1` -> `ready = 1`, `error = 1`, `rdata = 0`. A subsequent read of `0x10` still returns the previous value.
- Out-of-range read `adr = DEPTH_WORDS*4`, and a separate request with both strobes set -> `error = 1` on each pulse, and no memory change.
- Reset asserted during WAIT of a write to `0x20` (old value `0x5`):
  - No `ready` pulse.
  - After release, a read of `0x20` returns `0x5`.
